apb3_master_bridge: RTL and testbench
=====================================

Name: apb3_master_bridge

Overview:
- APB3 initiator (master) RTL.
- Converts a valid/ready command stream from an upstream controller (CPU bridge, DMA, register sequencer) into APB3 transfers to up to APB_NR_OF_SLAVES_P slaves.
- Decodes the slave from the address, multiplexes the slave responses back, and returns data and status on a valid/ready response channel.
- Serves as the design-under-test counterpart to the APB3 slave agent in the team's VIP.

Parameters:
- APB_ADDR_WIDTH_P, 32: width of paddr and cmd_addr.
- APB_DATA_WIDTH_P, 32: width of pwdata, prdata and cmd/rsp data.
- APB_NR_OF_SLAVES_P, 4: number of APB slaves (1..16). Does not need to be a power of two.
- APB_SLAVE_SEL_LSB_P, 16: LSB of the slave-index field in cmd_addr. Field width is SEL_W = max(1, $clog2(APB_NR_OF_SLAVES_P)).
- APB_TIMEOUT_P, 255: maximum ACCESS cycles without pready before abort (1..65535).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  APB_ADDR_WIDTH_P  byte address
- cmd_wdata  in  APB_DATA_WIDTH_P  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  APB_DATA_WIDTH_P  read data (0 for writes and errors)
- rsp_status  out  2  0 = OKAY, 1 = SLVERR, 2 = DECERR, 3 = TIMEOUT
- apb3_paddr  out  APB_ADDR_WIDTH_P  APB address
- apb3_psel  out  APB_NR_OF_SLAVES_P  one-hot slave select
- apb3_penable  out  1  APB enable
- apb3_pwrite  out  1  APB direction
- apb3_pwdata  out  APB_DATA_WIDTH_P  APB write data
- apb3_prdata  in  APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P  per-slave read data; slave i occupies bits [i*W +: W]
- apb3_pready  in  APB_NR_OF_SLAVES_P  per-slave ready
- apb3_pslverr  in  APB_NR_OF_SLAVES_P  per-slave error

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - All outputs 0 except cmd_ready = 1: apb3_psel, apb3_penable, apb3_paddr, apb3_pwdata, apb3_pwrite, rsp_valid, rsp_rdata, rsp_status all 0.
  - Timeout counter cleared.
  - Reset mid-transfer drops the transfer silently; no response is produced.
- FSM states IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On accept, register addr, wdata and write; idx = cmd_addr[APB_SLAVE_SEL_LSB_P +: SEL_W].
  - If idx < APB_NR_OF_SLAVES_P: drive paddr/pwrite/pwdata, set psel[idx] = 1, penable = 0, go to SETUP.
  - Else go to RESP with status DECERR and rdata 0. No APB activity occurs.
- SETUP: lasts exactly 1 cycle. Next cycle penable = 1, counter = 0, go to ACCESS.
- ACCESS:
  - psel, penable, paddr, pwrite and pwdata are held stable.
  - Only pready[idx], pslverr[idx] and prdata[idx] are observed; other slaves' inputs are ignored.
  - If pready[idx] = 1:
    - Drop psel and penable.
    - rsp_rdata = prdata[idx] when the transfer is a read and pslverr = 0; otherwise rsp_rdata = 0.
    - rsp_status = pslverr[idx] ? SLVERR : OKAY.
    - Go to RESP.
  - Else increment the counter. When the counter reaches APB_TIMEOUT_P without pready, drop psel and penable and go to RESP with TIMEOUT and rdata 0.
- RESP:
  - rsp_valid = 1; data and status are held stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE, cmd_ready = 1 the following cycle.
  - cmd_ready = 0 in SETUP, ACCESS and RESP. Only one outstanding command.
- Minimum latency:
  - Zero-wait-state slave: cmd accept (cycle 0), SETUP (1), ACCESS with pready (2), rsp_valid asserted in cycle 3.
  - Back-to-back throughput: one transfer per 4 cycles with rsp_ready tied high.
- apb3_psel is never multi-hot. penable is never 1 while psel is 0.
- paddr and pwdata keep their last value between transfers.
- pready sampled in the same cycle the counter hits the limit: pready wins and status is OKAY/SLVERR.

Test Plan:
- Write 0xDEADBEEF to addr 0x0001_0004 (slave 1), zero wait state -> psel = 0b0010, penable on 2nd bus cycle, pwrite = 1; rsp_valid on cycle 3 with status OKAY, rdata 0.
- Read addr 0x0003_0010; slave 3 holds pready low 5 cycles, then returns prdata 0x12345678 -> ACCESS lasts 6 cycles with signals held stable; rsp_rdata = 0x12345678, status OKAY.
- Write to slave 2 with pslverr = 1 at pready -> status SLVERR (1), rdata 0, cmd_ready returns after rsp handshake.
- APB_NR_OF_SLAVES_P = 3, access addr 0x0003_0000 -> no psel asserted at any time; rsp_status = DECERR (2) one cycle after accept.
- Slave never asserts pready, APB_TIMEOUT_P = 8 -> psel/penable drop after 8 ACCESS cycles; status TIMEOUT (3). Next command then completes normally.
- rsp_ready held low 10 cycles -> rsp_valid, rdata and status stable and cmd_ready = 0 throughout. Separately, rst_n pulsed low during ACCESS -> all outputs 0 immediately, cmd_ready = 1, no response emitted.

Source files
------------

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: turns a valid/ready command stream into APB3 transfers to one of
// APB_NR_OF_SLAVES_P slaves and returns data/status on a valid/ready response channel.
module apb3_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH_P    = 32,
  parameter int unsigned APB_DATA_WIDTH_P    = 32,
  parameter int unsigned APB_NR_OF_SLAVES_P  = 4,
  parameter int unsigned APB_SLAVE_SEL_LSB_P = 16,
  parameter int unsigned APB_TIMEOUT_P       = 255
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           cmd_valid,
  output logic                                           cmd_ready,
  input  logic                                           cmd_write,
  input  logic [APB_ADDR_WIDTH_P-1:0]                    cmd_addr,
  input  logic [APB_DATA_WIDTH_P-1:0]                    cmd_wdata,
  output logic                                           rsp_valid,
  input  logic                                           rsp_ready,
  output logic [APB_DATA_WIDTH_P-1:0]                    rsp_rdata,
  output logic [1:0]                                     rsp_status,
  output logic [APB_ADDR_WIDTH_P-1:0]                    apb3_paddr,
  output logic [APB_NR_OF_SLAVES_P-1:0]                  apb3_psel,
  output logic                                           apb3_penable,
  output logic                                           apb3_pwrite,
  output logic [APB_DATA_WIDTH_P-1:0]                    apb3_pwdata,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] apb3_prdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                  apb3_pready,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                  apb3_pslverr
);

  localparam int unsigned SEL_W = (APB_NR_OF_SLAVES_P > 1) ? $clog2(APB_NR_OF_SLAVES_P) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [1:0] ST_OKAY    = 2'd0;
  localparam logic [1:0] ST_SLVERR  = 2'd1;
  localparam logic [1:0] ST_DECERR  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(APB_TIMEOUT_P - 1);

  logic [1:0]                    state;
  logic [SEL_W-1:0]              idx;
  logic [SEL_W-1:0]              cmd_idx;
  logic [15:0]                   cnt;
  logic [APB_NR_OF_SLAVES_P-1:0] cmd_onehot;
  logic                          cmd_hit;
  logic                          sel_pready;
  logic                          sel_pslverr;
  logic [APB_DATA_WIDTH_P-1:0]   sel_prdata;

  assign cmd_idx = cmd_addr[APB_SLAVE_SEL_LSB_P +: SEL_W];

  // An index beyond the last slave leaves the one-hot empty, which doubles as the decode miss.
  always_comb begin
    cmd_onehot  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int unsigned i = 0; i < APB_NR_OF_SLAVES_P; i++) begin
      cmd_onehot[i] = (cmd_idx == SEL_W'(i));
      if (idx == SEL_W'(i)) begin
        sel_pready  = apb3_pready[i];
        sel_pslverr = apb3_pslverr[i];
        sel_prdata  = apb3_prdata[i*APB_DATA_WIDTH_P +: APB_DATA_WIDTH_P];
      end
    end
  end

  assign cmd_hit = |cmd_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_status   <= ST_OKAY;
      apb3_paddr   <= '0;
      apb3_psel    <= '0;
      apb3_penable <= 1'b0;
      apb3_pwrite  <= 1'b0;
      apb3_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_hit) begin
              apb3_paddr  <= cmd_addr;
              apb3_pwrite <= cmd_write;
              apb3_pwdata <= cmd_wdata;
              apb3_psel   <= cmd_onehot;
              idx         <= cmd_idx;
              state       <= SETUP;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_status <= ST_DECERR;
              rsp_rdata  <= '0;
              state      <= RESP;
            end
          end
        end
        SETUP: begin
          apb3_penable <= 1'b1;
          cnt          <= '0;
          state        <= ACCESS;
        end
        ACCESS: begin
          // pready is checked ahead of the limit so a late ready still completes normally.
          if (sel_pready) begin
            apb3_psel    <= '0;
            apb3_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_status   <= sel_pslverr ? ST_SLVERR : ST_OKAY;
            rsp_rdata    <= (!apb3_pwrite && !sel_pslverr) ? sel_prdata : '0;
            state        <= RESP;
          end else if (cnt == CNT_LAST) begin
            apb3_psel    <= '0;
            apb3_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_status   <= ST_TIMEOUT;
            rsp_rdata    <= '0;
            state        <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Bench for apb3_master_bridge: a 4-slave and a 3-slave instance (timeout 8) driven by
// directed table vectors, a reset-during-access sequence and random transactions.
module tb_apb3_master_bridge;

  localparam int T = 8;

  typedef struct {
    logic        b;        // 1 = three-slave instance
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;    // ACCESS cycles before pready; >= T means never in time
    logic        serr;
    logic [31:0] rd;
    int          hold;     // cycles rsp_ready stays low once rsp_valid is up
    logic [1:0]  e_status;
    logic [31:0] e_rdata;
    int          e_cyc;    // cycle of first rsp_valid, accept cycle = 0
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic use_b = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic rsp_ready = 1'b0;
  logic [127:0] prdata_in = '0;
  logic [3:0] pready_in = '0;
  logic [3:0] pslverr_in = '0;

  logic cmd_ready_a, rsp_valid_a, penable_a, pwrite_a;
  logic [31:0] rsp_rdata_a, paddr_a, pwdata_a;
  logic [1:0] rsp_status_a;
  logic [3:0] psel_a;
  logic cmd_ready_b, rsp_valid_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, paddr_b, pwdata_b;
  logic [1:0] rsp_status_b;
  logic [2:0] psel_b;

  logic cmd_ready, rsp_valid, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [1:0] rsp_status;
  logic [3:0] psel;

  int errors = 0;
  int checks = 0;
  int vec_id = 0;
  vec_t tbl[12];
  vec_t rv;

  always #5 clk = ~clk;

  apb3_master_bridge #(
    .APB_ADDR_WIDTH_P(32), .APB_DATA_WIDTH_P(32), .APB_NR_OF_SLAVES_P(4),
    .APB_SLAVE_SEL_LSB_P(16), .APB_TIMEOUT_P(T)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && !use_b), .cmd_ready(cmd_ready_a),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
    .rsp_status(rsp_status_a), .apb3_paddr(paddr_a), .apb3_psel(psel_a),
    .apb3_penable(penable_a), .apb3_pwrite(pwrite_a), .apb3_pwdata(pwdata_a),
    .apb3_prdata(prdata_in), .apb3_pready(pready_in), .apb3_pslverr(pslverr_in)
  );

  apb3_master_bridge #(
    .APB_ADDR_WIDTH_P(32), .APB_DATA_WIDTH_P(32), .APB_NR_OF_SLAVES_P(3),
    .APB_SLAVE_SEL_LSB_P(16), .APB_TIMEOUT_P(T)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && use_b), .cmd_ready(cmd_ready_b),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
    .rsp_status(rsp_status_b), .apb3_paddr(paddr_b), .apb3_psel(psel_b),
    .apb3_penable(penable_b), .apb3_pwrite(pwrite_b), .apb3_pwdata(pwdata_b),
    .apb3_prdata(prdata_in[95:0]), .apb3_pready(pready_in[2:0]), .apb3_pslverr(pslverr_in[2:0])
  );

  assign cmd_ready  = use_b ? cmd_ready_b  : cmd_ready_a;
  assign rsp_valid  = use_b ? rsp_valid_b  : rsp_valid_a;
  assign rsp_rdata  = use_b ? rsp_rdata_b  : rsp_rdata_a;
  assign rsp_status = use_b ? rsp_status_b : rsp_status_a;
  assign paddr      = use_b ? paddr_b      : paddr_a;
  assign pwdata     = use_b ? pwdata_b     : pwdata_a;
  assign pwrite     = use_b ? pwrite_b     : pwrite_a;
  assign penable    = use_b ? penable_b    : penable_a;
  assign psel       = use_b ? {1'b0, psel_b} : psel_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d: got %h expected %h at %0t", name, vec_id, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic b, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits, input logic serr,
                               input logic [31:0] rd, input int hold, input logic [1:0] es,
                               input logic [31:0] er, input int ec);
    vec_t v;
    v.b = b; v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.serr = serr;
    v.rd = rd; v.hold = hold; v.e_status = es; v.e_rdata = er; v.e_cyc = ec;
    return v;
  endfunction

  // Reference: decode miss answers next cycle; otherwise 1 SETUP cycle plus
  // min(waits+1, T) ACCESS cycles, with the response in the cycle after that.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r = v;
    int unsigned nslv = v.b ? 3 : 4;
    int unsigned sidx = 32'(v.addr[17:16]);
    if (sidx >= nslv) begin
      r.e_status = 2'd2; r.e_rdata = '0; r.e_cyc = 1;
    end else if (v.waits >= T) begin
      r.e_status = 2'd3; r.e_rdata = '0; r.e_cyc = 2 + T;
    end else begin
      r.e_status = v.serr ? 2'd1 : 2'd0;
      r.e_rdata  = (!v.wr && !v.serr) ? v.rd : 32'd0;
      r.e_cyc    = 3 + v.waits;
    end
    return r;
  endfunction

  // Entered just after a negedge; returns at the negedge where the bridge is idle again.
  task automatic run_xfer(input vec_t v);
    logic [1:0] idx;
    logic [3:0] onehot;
    bit dec;
    int last;
    idx    = v.addr[17:16];
    dec    = (32'(idx) >= (v.b ? 32'd3 : 32'd4));
    onehot = 4'b0001 << idx;
    last   = v.e_cyc + v.hold + 1;
    use_b  = v.b;
    #1;
    chk("accept_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("accept_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("accept_psel", 32'(psel), 32'd0);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    pready_in = 4'($urandom); pslverr_in = 4'($urandom);
    prdata_in = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready = 1'($urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      end
      if (c < v.e_cyc) begin
        chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("busy_psel", 32'(psel), 32'(onehot));
        chk("busy_penable", 32'(penable), 32'(c >= 2));
        chk("busy_paddr", paddr, v.addr);
        chk("busy_pwrite", 32'(pwrite), 32'(v.wr));
        chk("busy_pwdata", pwdata, v.wdata);
      end else if (c < last) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_status", 32'(rsp_status), 32'(v.e_status));
        chk("rsp_rdata", rsp_rdata, v.e_rdata);
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rsp_psel", 32'(psel), 32'd0);
        chk("rsp_penable", 32'(penable), 32'd0);
      end else begin
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("done_psel", 32'(psel), 32'd0);
        chk("done_penable", 32'(penable), 32'd0);
        if (!dec) begin
          chk("done_paddr_hold", paddr, v.addr);
          chk("done_pwdata_hold", pwdata, v.wdata);
        end
      end
      pready_in = 4'($urandom); pslverr_in = 4'($urandom);
      prdata_in = {$urandom, $urandom, $urandom, $urandom};
      if (!dec && c >= 2 && c < v.e_cyc) begin
        pready_in[idx] = (c == 2 + v.waits);
        if (c == 2 + v.waits) begin
          pslverr_in[idx] = v.serr;
          prdata_in[idx*32 +: 32] = v.rd;
        end
      end
      rsp_ready = (c < v.e_cyc) ? 1'($urandom) : 1'(c >= v.e_cyc + v.hold);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    //              b     wr    addr           wdata          waits serr  rd            hold  status rdata          cyc
    tbl[0]  = mkv(1'b0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 0,    1'b0, 32'h0,        0,    2'd0, 32'h0,         3);
    tbl[1]  = mkv(1'b0, 1'b0, 32'h0003_0010, 32'h0,         5,    1'b0, 32'h1234_5678, 0,   2'd0, 32'h1234_5678, 8);
    tbl[2]  = mkv(1'b0, 1'b1, 32'h0002_0020, 32'hA5A5_0001, 2,    1'b1, 32'h0,        1,    2'd1, 32'h0,         5);
    tbl[3]  = mkv(1'b1, 1'b0, 32'h0003_0000, 32'h0,         0,    1'b0, 32'h0,        0,    2'd2, 32'h0,         1);
    tbl[4]  = mkv(1'b1, 1'b0, 32'h0002_0000, 32'h0,         1,    1'b0, 32'h89AB_CDEF, 0,   2'd0, 32'h89AB_CDEF, 4);
    tbl[5]  = mkv(1'b0, 1'b0, 32'h0000_0008, 32'h0,         1000, 1'b0, 32'h0,        0,    2'd3, 32'h0,         10);
    tbl[6]  = mkv(1'b0, 1'b0, 32'hABCD_0000, 32'h0,         0,    1'b0, 32'hCAFE_F00D, 0,   2'd0, 32'hCAFE_F00D, 3);
    tbl[7]  = mkv(1'b0, 1'b0, 32'h0002_0004, 32'h0,         7,    1'b0, 32'h0BAD_F00D, 0,   2'd0, 32'h0BAD_F00D, 10);
    tbl[8]  = mkv(1'b0, 1'b1, 32'h0000_0100, 32'h1111_2222, 8,    1'b0, 32'h0,        0,    2'd3, 32'h0,         10);
    tbl[9]  = mkv(1'b0, 1'b0, 32'h0003_0000, 32'h0,         1,    1'b0, 32'h55AA_55AA, 10,  2'd0, 32'h55AA_55AA, 4);
    tbl[10] = mkv(1'b0, 1'b0, 32'h0001_0008, 32'h0,         0,    1'b1, 32'hFFFF_FFFF, 0,   2'd1, 32'h0,         3);
    tbl[11] = mkv(1'b1, 1'b1, 32'h0003_0000, 32'h7777_7777, 0,    1'b0, 32'h0,        2,    2'd2, 32'h0,         1);

    #2 rst_n = 1'b0;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_penable", 32'(penable), 32'd0);
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_pwrite", 32'(pwrite), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_status", 32'(rsp_status), 32'd0);
    use_b = 1'b1;
    #1;
    chk("reset_b_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_b_psel", 32'(psel), 32'd0);
    use_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      vec_id = i;
      run_xfer(tbl[i]);
    end

    // Reset pulse in the middle of an ACCESS phase to slave 1.
    vec_id = 100;
    use_b = 1'b0;
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0001_0040; cmd_wdata = 32'h0;
    pready_in = '0; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_penable", 32'(penable), 32'd1);
    chk("rst_mid_psel", 32'(psel), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_psel0", 32'(psel), 32'd0);
    chk("rst_mid_penable0", 32'(penable), 32'd0);
    chk("rst_mid_paddr0", paddr, 32'd0);
    chk("rst_mid_pwrite0", 32'(pwrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pready_in = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_psel", 32'(psel), 32'd0);
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      vec_id   = 200 + i;
      rv.b     = 1'($urandom);
      rv.wr    = 1'($urandom);
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.waits = int'($urandom_range(0, 10));
      rv.serr  = 1'($urandom);
      rv.rd    = $urandom;
      rv.hold  = int'($urandom_range(0, 3));
      rv       = ref_model(rv);
      run_xfer(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
